// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state, forward-select codes, default widths.
// Combinational definitions only; no latency or flow control.
package pipe_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } hazard_state_e;

   typedef logic [1:0] fwd_sel_e;

   localparam fwd_sel_e FWD_RF = 2'b00;
   localparam fwd_sel_e FWD_W  = 2'b01;
   localparam fwd_sel_e FWD_M  = 2'b10;

   localparam int PIPE_REG_AW = 5;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
// Counter outputs exist only when PIPE_PERF_CNT_EN is defined.
interface pipeline_hazard_ctrl_if
   import pipe_pkg::*;
#(
   parameter int REG_AW = PIPE_REG_AW,
   parameter int CNT_W  = 32
);

   logic [REG_AW-1:0] Rs1D, Rs2D;
   logic [REG_AW-1:0] Rs1E, Rs2E, RdE;
   logic [REG_AW-1:0] RdM, RdW;
   logic              RegWriteM, RegWriteW;
   logic              LoadE;
   logic              PCSrcE;
   logic              MemReqM, MemReadyM;

   logic              StallF, StallD, StallE, StallM;
   logic              FlushD, FlushE, FlushW;
   fwd_sel_e          ForwardAE, ForwardBE;

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0]  StallCycles, FlushCount;

   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      output RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM,
      input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
      input  ForwardAE, ForwardBE, StallCycles, FlushCount
   );

   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      input  RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM,
      output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
      output ForwardAE, ForwardBE, StallCycles, FlushCount
   );
`else
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("CNT_W must be at least 1");
   end

   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      output RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM,
      input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
      input  ForwardAE, ForwardBE
   );

   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      input  RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM,
      output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
      output ForwardAE, ForwardBE
   );
`endif

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_sel.sv
// Execute-operand forwarding selector; purely combinational.
// Memory-stage result wins over Writeback; x0 never forwards.
module fwd_sel
   import pipe_pkg::*;
#(
   parameter int REG_AW = PIPE_REG_AW
) (
   input  logic [REG_AW-1:0] rs,
   input  logic [REG_AW-1:0] rd_m,
   input  logic [REG_AW-1:0] rd_w,
   input  logic              reg_write_m,
   input  logic              reg_write_w,
   output fwd_sel_e          sel
);

   always_comb begin
      sel = FWD_RF;
      if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
         sel = FWD_M;
      end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
         sel = FWD_W;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward control for the 5-stage pipeline with a memory-wait freeze FSM.
// All controls are combinational in the same cycle; PIPE_PERF_CNT_EN adds saturating stall/flush counters.
module pipeline_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int REG_AW = PIPE_REG_AW,
   parameter int CNT_W  = 32
) (
   input logic                   clk,
   input logic                   rst,
   pipeline_hazard_ctrl_if.slave hz
);

   hazard_state_e state;
   logic          mem_stall;
   logic          lw_stall;
   fwd_sel_e      fwd_a;
   fwd_sel_e      fwd_b;

   fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
      .rs          (hz.Rs1E),
      .rd_m        (hz.RdM),
      .rd_w        (hz.RdW),
      .reg_write_m (hz.RegWriteM),
      .reg_write_w (hz.RegWriteW),
      .sel         (fwd_a)
   );

   fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
      .rs          (hz.Rs2E),
      .rd_m        (hz.RdM),
      .rd_w        (hz.RdW),
      .reg_write_m (hz.RegWriteM),
      .reg_write_w (hz.RegWriteW),
      .sel         (fwd_b)
   );

   assign mem_stall = ((state == MEM_WAIT) && !hz.MemReadyM) ||
                      ((state == RUN) && hz.MemReqM && !hz.MemReadyM);

   assign lw_stall = hz.LoadE && (hz.RdE != '0) &&
                     ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
      end else begin
         case (state)
            RUN:      if (hz.MemReqM && !hz.MemReadyM) state <= MEM_WAIT;
            MEM_WAIT: if (hz.MemReadyM) state <= RUN;
            default:  state <= RUN;
         endcase
      end
   end

   // A frozen pipeline defers the branch flush: E is held, so PCSrcE persists until release.
   always_comb begin
      hz.StallF    = 1'b0;
      hz.StallD    = 1'b0;
      hz.StallE    = 1'b0;
      hz.StallM    = 1'b0;
      hz.FlushD    = 1'b0;
      hz.FlushE    = 1'b0;
      hz.FlushW    = 1'b0;
      hz.ForwardAE = fwd_a;
      hz.ForwardBE = fwd_b;
      if (rst) begin
         hz.FlushD    = 1'b1;
         hz.FlushE    = 1'b1;
         hz.FlushW    = 1'b1;
         hz.ForwardAE = FWD_RF;
         hz.ForwardBE = FWD_RF;
      end else if (mem_stall) begin
         hz.StallF = 1'b1;
         hz.StallD = 1'b1;
         hz.StallE = 1'b1;
         hz.StallM = 1'b1;
         hz.FlushW = 1'b1;
      end else begin
         hz.StallF = lw_stall;
         hz.StallD = lw_stall;
         hz.FlushD = hz.PCSrcE;
         hz.FlushE = lw_stall || hz.PCSrcE;
      end
   end

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if ((mem_stall || lw_stall) && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
         end
         if (hz.PCSrcE && !mem_stall && (flush_count != '1)) begin
            flush_count <= flush_count + 1'b1;
         end
      end
   end

   assign hz.StallCycles = stall_cycles;
   assign hz.FlushCount  = flush_count;
`else
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("CNT_W must be at least 1");
   end
`endif

endmodule
